write_controller: RTL
=====================

Name: write_controller

Overview:
- Write-side companion of the register read controller on the UART packet bus.
- Accepts a write packet from the RX stream (one address byte, then DATA_LENGTH data bytes, MSB first) and assembles the 32-bit word.
- Issues a single-cycle write strobe to the register bank.
- With the optional feature enabled, returns a one-byte acknowledge packet on the TX stream.

Parameters:
- DATA_LENGTH, 4, number of data bytes per write packet (fixed 32-bit word; only 4 is supported).
- WRITE_DESTINATION, 8'h01, RX Destination value that selects this block.
- ACK_SOURCE, 8'h01, Source field placed on acknowledge packets.

Ports:
- ipClk  input  1  system clock, all logic on rising edge.
- ipReset  input  1  asynchronous, active-low reset.
- ipRxStream  input  UART_PACKET  incoming byte stream (Valid, SoP, EoP, Source, Destination, Length, Data[7:0]).
- opWriteAddress  output  8  register address of the current/last write.
- opWriteData  output  32  assembled write word.
- opWrite  output  1  one-cycle write strobe.
- ipTxReady  input  1  TX accepts a byte (used only with WRITE_ACK_EN).
- opTxStream  output  UART_PACKET  acknowledge stream (held idle without WRITE_ACK_EN).

Behaviour:
- Reset (ipReset low, asynchronous):
  - state=IDLE, byte counter=DATA_LENGTH.
  - opWrite=0, opWriteAddress=0, opWriteData=0.
  - opTxStream all fields 0, Valid=0.
- Byte acceptance: an RX byte is consumed only in a cycle with ipRxStream.Valid=1. Cycles without Valid change nothing.
- States: IDLE, GET_ADDRESS, GET_DATA, WRITE, ACK, DISCARD.
- IDLE:
  - Valid & SoP & Destination==WRITE_DESTINATION: capture Data into the address shadow, counter=DATA_LENGTH, go to GET_DATA.
  - Valid & SoP with any other Destination: go to DISCARD, unless EoP is also set, in which case stay in IDLE.
  - Valid without SoP: ignored.
- GET_ADDRESS: reserved for a split-SoP address phase; the RTL falls straight through it to IDLE.
- GET_DATA, on each valid byte:
  - Shift the byte into the data shadow (first byte lands in [31:24]); counter decrements.
  - Last byte (counter==1) with EoP=1: go to WRITE.
  - Last byte with EoP=0: oversize packet, go to DISCARD, no write.
  - EoP before the last byte: undersize packet, go to IDLE, no write.
  - SoP seen mid-packet: restart; treat this byte as a new address byte using the IDLE rules.
- WRITE (one cycle):
  - opWriteAddress and opWriteData load from the shadows; opWrite=1 for exactly this cycle.
  - Next state is ACK if WRITE_ACK_EN is defined, else IDLE.
  - Latency: opWrite is high on the 2nd rising edge after the edge that accepted the EoP byte.
- ACK: see Optional Feature.
- DISCARD: ignore bytes until a valid byte with EoP=1, then go to IDLE. A valid byte with SoP restarts the packet per the IDLE rules.
- Register outputs: opWriteAddress and opWriteData hold their last written values between writes. opWrite is otherwise 0.
- Reset mid-packet: the partial word is dropped and no strobe is issued.
- Back-to-back packets: a SoP arriving in the WRITE cycle is lost, so senders must leave at least one idle cycle. Without ACK, a SoP arriving in the IDLE cycle after WRITE is accepted normally.

Optional Feature:
- Macro: WRITE_ACK_EN.
- Defined: after WRITE, enter ACK and drive a single-byte packet on opTxStream:
  - Valid=1, SoP=1, EoP=1, Length=1.
  - Source=ACK_SOURCE, Destination=source of the write packet.
  - Data=address written.
  - Hold all fields until a cycle with ipTxReady=1, then drop Valid and return to IDLE.
  - RX bytes arriving while in ACK are ignored.
- Undefined: ACK state is unreachable; opTxStream stays all-zero; ipTxReady is unused.

Decomposition:
- Shared package Structures: existing UART_PACKET struct.
- Add constants READ_DESTINATION=8'h00 and WRITE_DESTINATION=8'h01, plus ACK length=1.
- State enum stays local to the module.
- No sub-module required. The byte-to-word shifter is small enough to stay inline.

Test Plan:
- Bytes {SoP, Dest 01, 0x05}, 0xDE, 0xAD, 0xBE, {EoP, 0xEF} -> one opWrite pulse; opWriteAddress=0x05, opWriteData=0xDEADBEEF.
- Same packet with Destination 0x00 -> no opWrite; next valid write packet to address 0x07 is still accepted.
- Undersize packet: address 0x02, then 0x11, then {EoP, 0x22} -> no opWrite; outputs keep their previous values.
- Oversize packet: address 0x03 plus 5 data bytes with EoP on the 5th -> no write; DISCARD exits on EoP and a following valid packet writes.
- ipReset pulsed low after the 2nd data byte -> all outputs 0 immediately; no strobe issued.
- WRITE_ACK_EN defined, ipTxReady held low for 3 cycles after the write -> opTxStream Valid=1, Data=0x05, Destination=write Source, held stable; released the cycle after ipTxReady=1.

Source files
------------

// File: rtl/write_controller_pkg.sv
// Shared UART packet bus definitions for the register read/write controllers.
package write_controller_pkg;

  // One byte on the UART packet bus with its framing and routing fields.
  typedef struct packed {
    logic       Valid;
    logic       SoP;
    logic       EoP;
    logic [7:0] Source;
    logic [7:0] Destination;
    logic [7:0] Length;
    logic [7:0] Data;
  } UART_PACKET;

  localparam logic [7:0] READ_DESTINATION  = 8'h00;
  localparam logic [7:0] WRITE_DESTINATION = 8'h01;
  localparam logic [7:0] ACK_LENGTH        = 8'h01;

endpackage

// File: rtl/write_controller.sv
// Write controller: assembles an address byte plus a 32-bit word from the RX
// packet stream and issues a single-cycle write strobe to the register bank.
// Optional macro WRITE_ACK_EN: return a one-byte acknowledge packet on TX.
module write_controller
  import write_controller_pkg::*;
#(
  parameter int unsigned DATA_LENGTH       = 4,
  parameter logic [7:0]  WRITE_DESTINATION = write_controller_pkg::WRITE_DESTINATION,
  parameter logic [7:0]  ACK_SOURCE        = 8'h01
) (
  input  logic        ipClk,
  input  logic        ipReset,
  input  UART_PACKET  ipRxStream,
  output logic [7:0]  opWriteAddress,
  output logic [31:0] opWriteData,
  output logic        opWrite,
  input  logic        ipTxReady,
  output UART_PACKET  opTxStream
);

  localparam int unsigned CntW = $clog2(DATA_LENGTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DATA_LENGTH);
  localparam logic [CntW-1:0] CntLast = CntW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StGetAddress,
    StGetData,
    StWrite,
    StAck,
    StDiscard
  } state_e;

  state_e          r_state;
  logic [CntW-1:0] r_count;
  logic [7:0]      r_addr_shadow;
  logic [31:0]     r_data_shadow;
  logic [7:0]      r_src_shadow;
  logic            r_write;
  logic [7:0]      r_write_address;
  logic [31:0]     r_write_data;
  UART_PACKET      r_tx;

  logic   w_rx_start;
  logic   w_for_us;
  logic   w_restart_ok;
  state_e w_start_state;

  assign w_rx_start   = ipRxStream.Valid & ipRxStream.SoP;
  assign w_for_us     = (ipRxStream.Destination == WRITE_DESTINATION);
  // A SoP restarts framing only where a packet may legally begin or be abandoned.
  assign w_restart_ok = (r_state == StIdle) || (r_state == StGetData) ||
                        (r_state == StDiscard);

  // Where a fresh SoP byte sends the FSM; a foreign single-byte packet needs no discard.
  always_comb begin
    w_start_state = StIdle;
    if (w_for_us) begin
      w_start_state = StGetData;
    end else if (!ipRxStream.EoP) begin
      w_start_state = StDiscard;
    end
  end

  // Packet framing FSM with registered write strobe, write outputs and TX stream.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      r_state         <= StIdle;
      r_count         <= CntFull;
      r_addr_shadow   <= '0;
      r_data_shadow   <= '0;
      r_src_shadow    <= '0;
      r_write         <= 1'b0;
      r_write_address <= '0;
      r_write_data    <= '0;
      r_tx            <= '0;
    end else begin
      r_write <= 1'b0;
      if (w_rx_start && w_restart_ok) begin
        r_state <= w_start_state;
        if (w_for_us) begin
          r_addr_shadow <= ipRxStream.Data;
          r_src_shadow  <= ipRxStream.Source;
          r_count       <= CntFull;
        end
      end else begin
        case (r_state)
          StIdle: ;
          StGetAddress: r_state <= StIdle;
          StGetData: begin
            if (ipRxStream.Valid) begin
              r_data_shadow <= {r_data_shadow[23:0], ipRxStream.Data};
              r_count       <= r_count - CntLast;
              if (r_count == CntLast) begin
                // Word complete: only a correctly terminated packet is written.
                r_state <= ipRxStream.EoP ? StWrite : StDiscard;
              end else if (ipRxStream.EoP) begin
                r_state <= StIdle;
              end
            end
          end
          StWrite: begin
            r_write         <= 1'b1;
            r_write_address <= r_addr_shadow;
            r_write_data    <= r_data_shadow;
`ifdef WRITE_ACK_EN
            r_tx.Valid       <= 1'b1;
            r_tx.SoP         <= 1'b1;
            r_tx.EoP         <= 1'b1;
            r_tx.Source      <= ACK_SOURCE;
            r_tx.Destination <= r_src_shadow;
            r_tx.Length      <= ACK_LENGTH;
            r_tx.Data        <= r_addr_shadow;
            r_state          <= StAck;
`else
            r_state <= StIdle;
`endif
          end
          StAck: begin
`ifdef WRITE_ACK_EN
            if (ipTxReady) begin
              r_tx    <= '0;
              r_state <= StIdle;
            end
`else
            r_state <= StIdle;
`endif
          end
          StDiscard: begin
            if (ipRxStream.Valid && ipRxStream.EoP) begin
              r_state <= StIdle;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  logic w_unused;
`ifdef WRITE_ACK_EN
  assign w_unused = ^{ipRxStream.Length, ACK_SOURCE};
`else
  // Without acknowledge support the TX handshake and the packet source are not needed.
  assign w_unused = ^{ipRxStream.Length, ipTxReady, r_src_shadow, ACK_SOURCE};
`endif

  assign opWrite        = r_write;
  assign opWriteAddress = r_write_address;
  assign opWriteData    = r_write_data;
  assign opTxStream     = r_tx;

endmodule
